// File: rtl/mm_fwd_source_if.sv
// Word-wide memory request/acknowledge bus between the MM stage and data memory.
interface mm_fwd_source_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, output we, output addr, output wdata,
                    input  rdata, input ack);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output rdata, output ack);
endinterface

// File: rtl/mm_fwd_source.sv
// MM-stage result register and data-memory sequencer driving the forwarding bus.
// Optional bus timeout enabled by defining MM_TIMEOUT_EN.
module mm_fwd_source #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [4:0]  ex_addr,
    input  logic [31:0] ex_value,
    input  logic [31:0] ex_store_data,
    input  logic [1:0]  ex_access_op,
    mm_fwd_source_if.master mem,
    output logic        stall_o,
    output logic [4:0]  fwd_addr,
    output logic [31:0] fwd_value,
    output logic [1:0]  fwd_access_op,
    output logic        bus_err
);
    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_D2R  = 2'd1;
    localparam logic [1:0] OP_M2R  = 2'd2;
    localparam logic [1:0] OP_R2M  = 2'd3;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t     state;
    logic [4:0] pend_addr;
    logic       discard;
`ifdef MM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt;
`else
    assign bus_err = 1'b0;
`endif

    // The ack cycle itself releases the pipeline.
    assign stall_o = (state == ST_WAIT) && !mem.ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            mem.req       <= 1'b0;
            mem.we        <= 1'b0;
            mem.addr      <= 32'd0;
            mem.wdata     <= 32'd0;
            pend_addr     <= 5'd0;
            discard       <= 1'b0;
            fwd_addr      <= 5'd0;
            fwd_value     <= 32'd0;
            fwd_access_op <= OP_NONE;
`ifdef MM_TIMEOUT_EN
            cnt           <= '0;
            bus_err       <= 1'b0;
`endif
        end else begin
`ifdef MM_TIMEOUT_EN
            bus_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (flush) begin
                        fwd_access_op <= OP_NONE;
                    end else begin
                        case (ex_access_op)
                            OP_D2R: begin
                                fwd_addr      <= ex_addr;
                                fwd_value     <= ex_value;
                                fwd_access_op <= (ex_addr == 5'd0) ? OP_NONE : OP_D2R;
                            end
                            OP_M2R, OP_R2M: begin
                                mem.req       <= 1'b1;
                                mem.we        <= (ex_access_op == OP_R2M);
                                mem.addr      <= {ex_value[31:2], 2'b00};
                                mem.wdata     <= ex_store_data;
                                pend_addr     <= ex_addr;
                                discard       <= 1'b0;
                                fwd_access_op <= OP_NONE;
                                state         <= ST_WAIT;
`ifdef MM_TIMEOUT_EN
                                cnt           <= '0;
`endif
                            end
                            default: fwd_access_op <= OP_NONE;
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (mem.ack) begin
                        mem.req <= 1'b0;
                        state   <= ST_IDLE;
                        // A flush now or earlier in this access drops the result.
                        if (flush || discard) begin
                            fwd_access_op <= OP_NONE;
                        end else if (mem.we) begin
                            fwd_addr      <= pend_addr;
                            fwd_access_op <= OP_R2M;
                        end else begin
                            fwd_addr      <= pend_addr;
                            fwd_value     <= mem.rdata;
                            fwd_access_op <= (pend_addr == 5'd0) ? OP_NONE : OP_M2R;
                        end
                    end else begin
                        if (flush) discard <= 1'b1;
`ifdef MM_TIMEOUT_EN
                        if (cnt == TO_LAST) begin
                            mem.req       <= 1'b0;
                            bus_err       <= 1'b1;
                            fwd_access_op <= OP_NONE;
                            state         <= ST_IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
